// File: rtl/fetch_redirect_sched.sv
// fetch_redirect_sched: IF0 fetch-PC owner. Arbitrates backend, IF3 and NLP
// redirects, sequences the slot-1 delay-slot fetch, buffers a redirect that
// arrives while fetch is paused, and raises the front-end flush pulses.
module fetch_redirect_sched #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             pause,
   input  logic             bk_valid,
   input  logic             bk_redirect,
   input  logic [31:0]      bk_pc,
   output logic             bk_ready,
   input  logic             if3_redirect,
   input  logic [31:0]      if3_pc,
   input  logic             nlp_v0,
   input  logic             nlp_v1,
   input  logic             nlp_tk0,
   input  logic             nlp_tk1,
   input  logic [31:0]      nlp_tgt0,
   input  logic [31:0]      nlp_tgt1,
   input  logic [31:0]      fall_pc,
   output logic [31:0]      pc,
   output logic             flush_front,
   output logic             flush_if3,
   output logic [CNT_W-1:0] redir_cnt
);

   typedef enum logic [1:0] {RUN, DS_WAIT, PEND} state_t;
   typedef enum logic {SRC_BK, SRC_IF3} src_t;

   state_t      state;
   src_t        pend_src;
   logic [31:0] pend_pc;
   logic [31:0] ds_tgt;
   logic        pend_bk;
   logic        bk_acc;

   // Saturating increment: the counter sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // A buffered backend redirect blocks further backend handshakes until it is applied.
   assign pend_bk  = (state == PEND) && (pend_src == SRC_BK);
   assign bk_ready = !pend_bk;
   assign bk_acc   = bk_valid && bk_redirect && bk_ready;

   // PC register, redirect state machine, registered flush pulses and counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         state       <= RUN;
         pend_src    <= SRC_IF3;
         pend_pc     <= '0;
         ds_tgt      <= '0;
         flush_front <= 1'b0;
         flush_if3   <= 1'b0;
         redir_cnt   <= '0;
      end else if (flush) begin
         // Same as reset except the redirect counter survives.
         pc          <= RESET_PC;
         state       <= RUN;
         pend_src    <= SRC_IF3;
         pend_pc     <= '0;
         ds_tgt      <= '0;
         flush_front <= 1'b0;
         flush_if3   <= 1'b0;
      end else begin
         flush_front <= 1'b0;
         flush_if3   <= 1'b0;
         if (!pause) begin
            if (bk_acc) begin
               pc          <= bk_pc;
               flush_front <= 1'b1;
               flush_if3   <= 1'b1;
               state       <= RUN;
               redir_cnt   <= sat_inc(redir_cnt);
            end else if (state == PEND) begin
               pc          <= pend_pc;
               flush_front <= 1'b1;
               flush_if3   <= (pend_src == SRC_BK);
               state       <= RUN;
               redir_cnt   <= sat_inc(redir_cnt);
            end else if (if3_redirect) begin
               pc          <= if3_pc;
               flush_front <= 1'b1;
               state       <= RUN;
               redir_cnt   <= sat_inc(redir_cnt);
            end else if (state == DS_WAIT) begin
               // Delay slot already fetched; now jump to the held slot-1 target.
               pc    <= ds_tgt;
               state <= RUN;
            end else if (nlp_v0 && nlp_tk0) begin
               pc <= nlp_tgt0;
            end else if (nlp_v1 && nlp_tk1) begin
               pc     <= fall_pc;
               ds_tgt <= nlp_tgt1;
               state  <= DS_WAIT;
            end else begin
               pc <= fall_pc;
            end
         end else begin
            // Paused: pc holds, NLP ignored; redirects are buffered (BK wins, never overwritten).
            if (bk_acc) begin
               pend_pc  <= bk_pc;
               pend_src <= SRC_BK;
               state    <= PEND;
            end else if (if3_redirect && !pend_bk) begin
               pend_pc  <= if3_pc;
               pend_src <= SRC_IF3;
               state    <= PEND;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_redirect_sched.sv
// Directed bench for fetch_redirect_sched: stimulus queues hand-computed
// expectations per cycle, a monitor pops and compares them on the falling edge.
module tb_fetch_redirect_sched;

   logic        clk = 1'b0;
   logic        rst, flush, pause;
   logic        bk_valid, bk_redirect;
   logic [31:0] bk_pc;
   logic        bk_ready;
   logic        if3_redirect;
   logic [31:0] if3_pc;
   logic        nlp_v0, nlp_v1, nlp_tk0, nlp_tk1;
   logic [31:0] nlp_tgt0, nlp_tgt1, fall_pc;
   logic [31:0] pc;
   logic        flush_front, flush_if3;
   logic [15:0] redir_cnt;

   always #5 clk = ~clk;

   fetch_redirect_sched #(.RESET_PC(32'hBFC0_0000), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush), .pause(pause),
      .bk_valid(bk_valid), .bk_redirect(bk_redirect), .bk_pc(bk_pc), .bk_ready(bk_ready),
      .if3_redirect(if3_redirect), .if3_pc(if3_pc),
      .nlp_v0(nlp_v0), .nlp_v1(nlp_v1), .nlp_tk0(nlp_tk0), .nlp_tk1(nlp_tk1),
      .nlp_tgt0(nlp_tgt0), .nlp_tgt1(nlp_tgt1), .fall_pc(fall_pc),
      .pc(pc), .flush_front(flush_front), .flush_if3(flush_if3), .redir_cnt(redir_cnt)
   );

   // mask bits: 0 pc, 1 flush pulses, 2 bk_ready, 3 redir_cnt
   typedef struct {
      string       nm;
      int          m;
      logic [31:0] pc;
      logic        ff;
      logic        fi;
      logic        rdy;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   localparam int PC = 1, FL = 2, RD = 4, CN = 8, ALL = 15;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", nm, act, req);
   endtask

   // Monitor: outputs are sampled mid-cycle, well away from the rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.m & PC) chk({e.nm, ".pc"}, pc, e.pc);
         if (e.m & FL) begin
            chk({e.nm, ".flush_front"}, {31'b0, flush_front}, {31'b0, e.ff});
            chk({e.nm, ".flush_if3"},   {31'b0, flush_if3},   {31'b0, e.fi});
         end
         if (e.m & RD) chk({e.nm, ".bk_ready"}, {31'b0, bk_ready}, {31'b0, e.rdy});
         if (e.m & CN) chk({e.nm, ".redir_cnt"}, {16'b0, redir_cnt}, {16'b0, e.cnt});
      end
   end

   // Advance one clock with the currently driven inputs and queue the expected result.
   task automatic cyc(input string nm, input int m, input logic [31:0] epc,
                      input logic eff, input logic efi, input logic erdy, input logic [15:0] ecnt);
      exp_t e;
      @(posedge clk);
      #1;
      e.nm = nm; e.m = m; e.pc = epc; e.ff = eff; e.fi = efi; e.rdy = erdy; e.cnt = ecnt;
      exp_q.push_back(e);
   endtask

   task automatic idle_inputs();
      rst = 0; flush = 0; pause = 0;
      bk_valid = 0; bk_redirect = 0; bk_pc = '0;
      if3_redirect = 0; if3_pc = '0;
      nlp_v0 = 0; nlp_v1 = 0; nlp_tk0 = 0; nlp_tk1 = 0;
      nlp_tgt0 = '0; nlp_tgt1 = '0; fall_pc = '0;
   endtask

   initial begin
      idle_inputs();
      // 1 reset and sequential fetch
      rst = 1;
      for (int i = 0; i < 3; i++) cyc("rst", ALL, 32'hBFC0_0000, 0, 0, 1, 16'd0);
      rst = 0; fall_pc = 32'h8000_0000;
      cyc("seq0", ALL, 32'h8000_0000, 0, 0, 1, 16'd0);
      fall_pc = 32'h8000_0004;
      cyc("seq1", ALL, 32'h8000_0004, 0, 0, 1, 16'd0);

      // 2 slot-1 taken: delay slot then target
      nlp_v1 = 1; nlp_tk1 = 1; nlp_tgt1 = 32'h8000_0100; fall_pc = 32'h8000_0008;
      cyc("ds_slot", ALL, 32'h8000_0008, 0, 0, 1, 16'd0);
      nlp_v1 = 0; nlp_tk1 = 0; fall_pc = 32'h8000_000C;
      cyc("ds_tgt", ALL, 32'h8000_0100, 0, 0, 1, 16'd0);

      // 3 DS_WAIT held across pause
      nlp_v1 = 1; nlp_tk1 = 1; nlp_tgt1 = 32'h8000_0300; fall_pc = 32'h8000_0010;
      cyc("ds2_slot", ALL, 32'h8000_0010, 0, 0, 1, 16'd0);
      nlp_v1 = 0; nlp_tk1 = 0; pause = 1; fall_pc = 32'h8000_0014;
      cyc("ds2_hold0", ALL, 32'h8000_0010, 0, 0, 1, 16'd0);
      cyc("ds2_hold1", ALL, 32'h8000_0010, 0, 0, 1, 16'd0);
      pause = 0;
      cyc("ds2_rel", ALL, 32'h8000_0300, 0, 0, 1, 16'd0);

      // 4 paused IF3 then BK: BK wins and is not overwritten
      pause = 1; if3_redirect = 1; if3_pc = 32'h8000_0040;
      cyc("pend_if3", ALL, 32'h8000_0300, 0, 0, 1, 16'd0);
      if3_redirect = 0; bk_valid = 1; bk_redirect = 1; bk_pc = 32'h8000_0200;
      cyc("pend_bk", ALL, 32'h8000_0300, 0, 0, 0, 16'd0);
      bk_valid = 0; bk_redirect = 0; if3_redirect = 1; if3_pc = 32'h8000_0050;
      cyc("pend_keep", ALL, 32'h8000_0300, 0, 0, 0, 16'd0);
      if3_redirect = 0; pause = 0; fall_pc = 32'h8000_0020;
      cyc("pend_rel", ALL, 32'h8000_0200, 1, 1, 1, 16'd1);
      fall_pc = 32'h8000_0024;
      cyc("pend_after", ALL, 32'h8000_0024, 0, 0, 1, 16'd1);

      // 5 priority: bk over IF3 over NLP
      bk_valid = 1; bk_redirect = 1; bk_pc = 32'h8000_0400;
      if3_redirect = 1; if3_pc = 32'h8000_0500;
      nlp_v0 = 1; nlp_tk0 = 1; nlp_tgt0 = 32'h8000_0600;
      cyc("prio_bk", ALL, 32'h8000_0400, 1, 1, 1, 16'd2);
      bk_valid = 0; bk_redirect = 0; if3_pc = 32'h8000_0700;
      cyc("prio_if3", ALL, 32'h8000_0700, 1, 0, 1, 16'd3);
      if3_redirect = 0; nlp_tgt0 = 32'h8000_0800;
      cyc("nlp0", ALL, 32'h8000_0800, 0, 0, 1, 16'd3);
      nlp_v0 = 0; nlp_tk0 = 0; bk_valid = 1; bk_redirect = 0; bk_pc = 32'h8000_0F00;
      fall_pc = 32'h8000_0804;
      cyc("bk_noreq", ALL, 32'h8000_0804, 0, 0, 1, 16'd3);

      // 6 flush clears a buffered BK, keeps the counter
      pause = 1; bk_redirect = 1; bk_pc = 32'h8000_0900;
      cyc("fl_pend", ALL, 32'h8000_0804, 0, 0, 0, 16'd3);
      bk_valid = 0; bk_redirect = 0; flush = 1;
      cyc("flush", ALL, 32'hBFC0_0000, 0, 0, 1, 16'd3);
      flush = 0; pause = 0; fall_pc = 32'h8000_0A00;
      cyc("fl_after", ALL, 32'h8000_0A00, 0, 0, 1, 16'd3);
      pause = 1; if3_redirect = 1; if3_pc = 32'h8000_0B00;
      cyc("pif3_buf", ALL, 32'h8000_0A00, 0, 0, 1, 16'd3);
      if3_redirect = 0; pause = 0;
      cyc("pif3_rel", ALL, 32'h8000_0B00, 1, 0, 1, 16'd4);

      // counter saturation: 2^16+3 redirects after a reset
      rst = 1;
      cyc("rst2", ALL, 32'hBFC0_0000, 0, 0, 1, 16'd0);
      rst = 0; if3_redirect = 1; if3_pc = 32'h8000_0C00;
      repeat (65533) @(posedge clk);
      cyc("cnt_fffe", PC | CN, 32'h8000_0C00, 0, 0, 1, 16'hFFFE);
      for (int i = 0; i < 5; i++) cyc("cnt_sat", CN, '0, 0, 0, 1, 16'hFFFF);
      if3_redirect = 0;

      // drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      @(posedge clk);
      if (exp_q.size() != 0) begin
         n_chk++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
